// File: rtl/fib_seq_ctrl_pkg.sv
// Shared definitions for the Fibonacci sequencing stage: FSM state encodings
// and default term width / seed values.
package fib_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_F0    = 0;
  localparam int DEF_F1    = 1;

endpackage

// File: rtl/fib_pair_reg.sv
// Holds the (prev, curr) Fibonacci term pair plus a sticky carry flag that
// marks the point where the next term no longer fits in WIDTH bits.
module fib_pair_reg #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] F0    = '0,
  parameter logic [WIDTH-1:0] F1    = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] prev,
  output logic             flag
);

  logic [WIDTH-1:0] curr;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, prev} + {1'b0, curr};

  // Load has priority so a restart always reseeds, whatever advance is doing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev <= '0;
      curr <= '0;
      flag <= 1'b0;
    end else if (load) begin
      prev <= F0;
      curr <= F1;
      flag <= 1'b0;
    end else if (advance) begin
      prev <= curr;
      curr <= sum[WIDTH-1:0];
      flag <= flag | sum[WIDTH];
    end
  end

endmodule

// File: rtl/fib_seq_ctrl.sv
// Sequencing stage: emits one Fibonacci term per accepted beat on a
// valid/ready stream, stopping on a term limit or on arithmetic overflow.
module fib_seq_ctrl
  import fib_seq_ctrl_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               MAX_TERMS = 16,
  parameter int               IDX_W     = 5,
  parameter logic [WIDTH-1:0] F0        = WIDTH'(DEF_F0),
  parameter logic [WIDTH-1:0] F1        = WIDTH'(DEF_F1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_term,
  output logic [IDX_W-1:0] out_index,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_TERMS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             ovf_q;
  logic             load, advance, set_ovf;
  logic             beat;
  logic [WIDTH-1:0] prev;
  logic             flag;

  fib_pair_reg #(
    .WIDTH (WIDTH),
    .F0    (F0),
    .F1    (F1)
  ) u_pair (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .advance (advance),
    .prev    (prev),
    .flag    (flag)
  );

  assign beat = (state_q == EMIT) && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        idx_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (advance) idx_q <= idx_q + IDX_W'(1);
        if (set_ovf) ovf_q <= 1'b1;
      end
    end
  end

  // The pair only advances on a beat that keeps the run going, so prev and
  // idx keep showing the last emitted term once the run stops or is halted.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    set_ovf = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (halt) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = EMIT;
          load    = 1'b1;
        end
      end
      EMIT: begin
        if (halt) begin
          state_d = IDLE;
        end else if (beat) begin
          if (flag) begin
            state_d = DONE;
            set_ovf = 1'b1;
          end else if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q == EMIT);
  assign done      = (state_q == DONE);
  assign out_term  = prev;
  assign out_index = idx_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench for fib_seq_ctrl: default instance plus a MAX_TERMS=5 instance.
module tb_fib_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, halt = 1'b0, out_ready = 1'b0;
  logic       out_valid, busy, done, ovf;
  logic [3:0] out_term;
  logic [4:0] out_index;

  logic       start_b = 1'b0, halt_b = 1'b0, ready_b = 1'b1;
  logic       valid_b, busy_b, done_b, ovf_b;
  logic [3:0] term_b;
  logic [4:0] index_b;

  int passed = 0;
  int total  = 0;

  fib_seq_ctrl dut_a (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .out_ready(out_ready),
    .out_valid(out_valid), .out_term(out_term), .out_index(out_index),
    .busy(busy), .done(done), .ovf(ovf)
  );

  fib_seq_ctrl #(.MAX_TERMS(5)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .halt(halt_b), .out_ready(ready_b),
    .out_valid(valid_b), .out_term(term_b), .out_index(index_b),
    .busy(busy_b), .done(done_b), .ovf(ovf_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: run did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    logic [3:0] fib_a [8];
    logic [3:0] fib_b [5];
    fib_a = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13};
    fib_b = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3};

    // reset state
    #12;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_ovf",   32'(ovf), 0);
    check("rst_term",  32'(out_term), 0);
    check("rst_index", 32'(out_index), 0);
    reset = 1'b1;
    tick();

    // full default run ending on overflow
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("t1_valid", 32'(out_valid), 1);
      check("t1_term",  32'(out_term), 32'(fib_a[k]));
      check("t1_index", 32'(out_index), k);
      tick();
    end
    check("t1_done",  32'(done), 1);
    check("t1_ovf",   32'(ovf), 1);
    check("t1_valid_end", 32'(out_valid), 0);
    check("t1_term_hold", 32'(out_term), 13);
    tick();
    check("t1_done_hold", 32'(done), 1);

    // restart from DONE clears ovf and re-emits term 0
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_ovf_clr", 32'(ovf), 0);
    check("t5_term0",   32'(out_term), 0);
    check("t5_index0",  32'(out_index), 0);
    check("t5_valid",   32'(out_valid), 1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_ign_term",  32'(out_term), 1);
    check("t5_ign_index", 32'(out_index), 2);
    tick();

    // backpressure on term 2 at idx 3
    out_ready = 1'b0;
    check("t3_term_pre", 32'(out_term), 2);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_term_hold",  32'(out_term), 2);
      check("t3_index_hold", 32'(out_index), 3);
      check("t3_valid_hold", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    tick();
    check("t3_term_next",  32'(out_term), 3);
    check("t3_index_next", 32'(out_index), 4);

    // halt coincident with a beat on term 3
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("t4_valid", 32'(out_valid), 0);
    check("t4_busy",  32'(busy), 0);
    check("t4_done",  32'(done), 0);
    tick();
    check("t4_idle_stay", 32'(out_valid), 0);
    start = 1'b1;
    halt  = 1'b1;
    tick();
    check("sh_halt_wins", 32'(busy), 0);
    halt = 1'b0;
    tick();
    start = 1'b0;
    check("t4_restart_term",  32'(out_term), 0);
    check("t4_restart_index", 32'(out_index), 0);
    check("t4_restart_valid", 32'(out_valid), 1);
    tick();
    tick();
    check("t6_pre_index", 32'(out_index), 2);

    // asynchronous reset off the clock edge
    #2;
    reset = 1'b0;
    #1;
    check("t6_valid", 32'(out_valid), 0);
    check("t6_busy",  32'(busy), 0);
    check("t6_done",  32'(done), 0);
    check("t6_ovf",   32'(ovf), 0);
    check("t6_term",  32'(out_term), 0);
    #3;
    reset = 1'b1;
    tick();
    tick();
    check("t6_stay_idle", 32'(out_valid), 0);
    check("t6_stay_busy", 32'(busy), 0);

    // term limit of 5 on the second instance
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("t2_valid", 32'(valid_b), 1);
      check("t2_term",  32'(term_b), 32'(fib_b[k]));
      check("t2_index", 32'(index_b), k);
      tick();
    end
    check("t2_done",  32'(done_b), 1);
    check("t2_ovf",   32'(ovf_b), 0);
    check("t2_valid_end", 32'(valid_b), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
